// File: rtl/ps2_cmd_pkg.sv
// Shared definitions for the PS/2 command parser: FSM states, ASCII constants
// and error codes.
package ps2_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HI_GOT    = 3'd1,
        ST_LO_GOT    = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_UA    = 8'h41;
    localparam logic [7:0] ASCII_LA    = 8'h61;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_INVALID   = 2'd1;
    localparam logic [1:0] ERR_MALFORMED = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

endpackage

// File: rtl/ps2_cmd_parser_ascii_hex_decoder.sv
// Combinational ASCII classifier: hex digit value plus hex/whitespace flags.
module ascii_hex_decoder
    import ps2_cmd_pkg::*;
(
    input  logic [7:0] i_char,
    output logic [3:0] o_nibble,
    output logic       o_is_hex,
    output logic       o_is_ws
);

    logic [7:0] w_offset;

    always_comb begin
        w_offset = 8'h00;
        o_is_hex = 1'b0;
        if (i_char >= ASCII_0 && i_char <= ASCII_0 + 8'd9) begin
            w_offset = i_char - ASCII_0;
            o_is_hex = 1'b1;
        end else if (i_char >= ASCII_UA && i_char <= ASCII_UA + 8'd5) begin
            w_offset = i_char - ASCII_UA + 8'd10;
            o_is_hex = 1'b1;
        end else if (i_char >= ASCII_LA && i_char <= ASCII_LA + 8'd5) begin
            w_offset = i_char - ASCII_LA + 8'd10;
            o_is_hex = 1'b1;
        end
    end

    assign o_nibble = w_offset[3:0];
    assign o_is_ws  = (i_char == ASCII_SPACE) || (i_char == ASCII_CR) || (i_char == ASCII_LF);

endmodule

// File: rtl/ps2_cmd_parser.sv
// Parses whitespace-separated two-digit hex tokens from the UART RX FIFO and
// hands each byte to the PS/2 transmitter, waiting (with timeout) for completion.
module ps2_cmd_parser
    import ps2_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2_500_000,
    parameter int TO_W        = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_empty,
    input  logic [7:0] rd_data,
    output logic       rd,
    input  logic       ps2_tx_idle,
    input  logic       tx_done_tick,
    output logic       wr_ps2,
    output logic [7:0] ps2_din,
    output logic       err_tick,
    output logic [1:0] err_code,
    output logic       busy
);

    state_t            r_state;
    state_t            w_stateNext;
    logic [7:0]        r_byte;
    logic [7:0]        w_byteNext;
    logic [1:0]        r_errCode;
    logic [1:0]        w_errCodeNext;
    logic [TO_W-1:0]   r_toCnt;
    logic [TO_W-1:0]   w_toCntNext;
    logic [3:0]        w_nibble;
    logic              w_isHex;
    logic              w_isWs;

    ascii_hex_decoder u_dec (
        .i_char   (rd_data),
        .o_nibble (w_nibble),
        .o_is_hex (w_isHex),
        .o_is_ws  (w_isWs)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_byte    <= 8'h00;
            r_errCode <= ERR_NONE;
            r_toCnt   <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_byte    <= w_byteNext;
            r_errCode <= w_errCodeNext;
            r_toCnt   <= w_toCntNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_byteNext    = r_byte;
        w_errCodeNext = r_errCode;
        w_toCntNext   = r_toCnt;
        rd            = 1'b0;
        wr_ps2        = 1'b0;
        err_tick      = 1'b0;
        busy          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                rd = !rx_empty;
                if (!rx_empty) begin
                    if (w_isHex) begin
                        w_byteNext[7:4] = w_nibble;
                        w_stateNext     = ST_HI_GOT;
                    end else if (!w_isWs) begin
                        err_tick      = 1'b1;
                        w_errCodeNext = ERR_INVALID;
                    end
                end
            end
            ST_HI_GOT: begin
                rd = !rx_empty;
                if (!rx_empty) begin
                    err_tick    = !w_isHex;
                    w_stateNext = ST_IDLE;
                    if (w_isHex) begin
                        w_byteNext[3:0] = w_nibble;
                        w_stateNext     = ST_LO_GOT;
                    end else if (w_isWs) begin
                        w_errCodeNext = ERR_MALFORMED;
                    end else begin
                        w_errCodeNext = ERR_INVALID;
                    end
                end
            end
            ST_LO_GOT: begin
                rd = !rx_empty;
                if (!rx_empty) begin
                    if (w_isWs) begin
                        w_stateNext = ST_SEND;
                    end else if (w_isHex) begin
                        // A third digit is flagged but also opens the next token
                        err_tick        = 1'b1;
                        w_errCodeNext   = ERR_MALFORMED;
                        w_byteNext[7:4] = w_nibble;
                        w_stateNext     = ST_HI_GOT;
                    end else begin
                        err_tick      = 1'b1;
                        w_errCodeNext = ERR_INVALID;
                        w_stateNext   = ST_IDLE;
                    end
                end
            end
            ST_SEND: begin
                busy = 1'b1;
                if (ps2_tx_idle) begin
                    wr_ps2      = 1'b1;
                    w_toCntNext = '0;
                    w_stateNext = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                busy        = 1'b1;
                w_toCntNext = r_toCnt + 1'b1;
                if (tx_done_tick) begin
                    w_stateNext = ST_IDLE;
                end else if (r_toCnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    err_tick      = 1'b1;
                    w_errCodeNext = ERR_TIMEOUT;
                    w_stateNext   = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    assign ps2_din  = r_byte;
    assign err_code = r_errCode;

endmodule

// File: tb/tb_ps2_cmd_parser.sv
// Self-checking bench: directed cases plus random text compared against a
// token-level reference model of the command parser.
module tb_ps2_cmd_parser;

    localparam int TIMEOUT_CYC = 16;
    localparam int TO_W        = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_empty;
    logic [7:0] rd_data;
    logic       rd;
    logic       ps2_tx_idle;
    logic       tx_done_tick;
    logic       wr_ps2;
    logic [7:0] ps2_din;
    logic       err_tick;
    logic [1:0] err_code;
    logic       busy;

    always #5 clk = ~clk;

    ps2_cmd_parser #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_empty     (rx_empty),
        .rd_data      (rd_data),
        .rd           (rd),
        .ps2_tx_idle  (ps2_tx_idle),
        .tx_done_tick (tx_done_tick),
        .wr_ps2       (wr_ps2),
        .ps2_din      (ps2_din),
        .err_tick     (err_tick),
        .err_code     (err_code),
        .busy         (busy)
    );

    typedef struct packed {
        logic       isErr;
        logic [7:0] val;
    } ev_t;

    logic [7:0] fifoQ[$];
    ev_t        expQ[$];
    ev_t        obsQ[$];
    int         nChecks = 0;
    int         nErrors = 0;
    logic       tbIdle, tbDone, autoTx, prevErr;
    int         txLeft;
    logic       cRd, cWr, cErr, cBusy;
    logic [7:0] cDin;
    int         mTokLen;
    int         mTok;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int hexVal(input logic [7:0] c);
        int v = int'(c);
        if (v >= 48 && v <= 57)  return v - 48;
        if (v >= 65 && v <= 70)  return v - 55;
        if (v >= 97 && v <= 102) return v - 87;
        return -1;
    endfunction

    function automatic bit isWs(input logic [7:0] c);
        return (c == 8'd32) || (c == 8'd13) || (c == 8'd10);
    endfunction

    // Token-level model: a token is one or two hex digits collected between separators
    task automatic modelChar(input logic [7:0] c);
        int v = hexVal(c);
        if (v >= 0) begin
            if (mTokLen == 2) begin
                expQ.push_back(ev_t'{1'b1, 8'd2});
                mTok = v; mTokLen = 1;
            end else if (mTokLen == 0) begin
                mTok = v; mTokLen = 1;
            end else begin
                mTok = mTok * 16 + v; mTokLen = 2;
            end
        end else if (isWs(c)) begin
            if (mTokLen == 1) expQ.push_back(ev_t'{1'b1, 8'd2});
            if (mTokLen == 2) expQ.push_back(ev_t'{1'b0, 8'(mTok)});
            mTokLen = 0;
        end else begin
            expQ.push_back(ev_t'{1'b1, 8'd1});
            mTokLen = 0;
        end
    endtask

    task automatic pushText(input string s);
        for (int i = 0; i < s.len(); i++) begin
            fifoQ.push_back(s[i]);
            modelChar(s[i]);
        end
    endtask

    // One clock cycle: drive at negedge, sample just after, then advance
    task automatic cycle();
        if (autoTx) begin
            tbDone = (txLeft == 1);
            tbIdle = (txLeft == 0) && ($urandom_range(0, 3) != 0);
        end
        rx_empty     = (fifoQ.size() == 0);
        rd_data      = rx_empty ? 8'h00 : fifoQ[0];
        ps2_tx_idle  = tbIdle;
        tx_done_tick = tbDone;
        #1;
        cRd = rd; cWr = wr_ps2; cErr = err_tick; cBusy = busy; cDin = ps2_din;
        if (prevErr) obsQ.push_back(ev_t'{1'b1, {6'd0, err_code}});
        if (cWr) obsQ.push_back(ev_t'{1'b0, cDin});
        prevErr = cErr;
        if (cRd && fifoQ.size() > 0) void'(fifoQ.pop_front());
        if (autoTx) begin
            if (txLeft > 0) txLeft--;
            if (cWr) txLeft = $urandom_range(2, 12);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int maxCyc);
        int n = 0;
        int idleRun = 0;
        while (n < maxCyc && idleRun < 2) begin
            cycle();
            n++;
            if (fifoQ.size() == 0 && !cBusy && !prevErr) idleRun++;
            else idleRun = 0;
        end
        check({tag, "_drain"}, idleRun >= 2, 1);
    endtask

    task automatic compareEvents(input string tag);
        int n;
        check({tag, "_count"}, obsQ.size(), expQ.size());
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_ev%0d", tag, i), obsQ[i], expQ[i]);
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic doReset(input int nCyc);
        rst_n = 1'b0;
        fifoQ.delete();
        mTokLen = 0; txLeft = 0; tbDone = 1'b0; tbIdle = 1'b1;
        for (int i = 0; i < nCyc; i++) cycle();
        rst_n = 1'b1;
        prevErr = 1'b0;
        obsQ.delete();
        expQ.delete();
    endtask

    initial begin
        int         errAt;
        logic       anyWr, anyRd, errSeen;
        int         r;
        logic [7:0] ch;
        string      hexChars = "0123456789abcdefABCDEF";
        string      wsChars  = " \r\n";

        rst_n = 1'b0; rx_empty = 1'b1; rd_data = 8'h00;
        ps2_tx_idle = 1'b1; tx_done_tick = 1'b0;
        autoTx = 1'b0; tbIdle = 1'b1; tbDone = 1'b0; txLeft = 0;
        prevErr = 1'b0; mTokLen = 0; mTok = 0;
        @(negedge clk);

        rst_n = 1'b0;
        cycle(); cycle(); cycle();
        check("reset_rd", cRd, 0);
        check("reset_wr", cWr, 0);
        check("reset_err", cErr, 0);
        check("reset_busy", cBusy, 0);
        check("reset_din", cDin, 8'h00);
        check("reset_errcode", err_code, 2'd0);
        rst_n = 1'b1;
        obsQ.delete();

        $display("[TB] basic token ED");
        pushText("ED ");
        cycle(); check("ed_rd1", cRd, 1);
        cycle(); check("ed_rd2", cRd, 1);
        cycle(); check("ed_rd3", cRd, 1); check("ed_busy3", cBusy, 0);
        cycle(); check("ed_wr", cWr, 1); check("ed_din", cDin, 8'hED);
        check("ed_busy_send", cBusy, 1); check("ed_rd_send", cRd, 0);
        cycle(); check("ed_wr_once", cWr, 0); check("ed_busy_wait", cBusy, 1);
        tbDone = 1'b1;
        cycle(); check("ed_busy_done", cBusy, 1);
        tbDone = 1'b0;
        cycle(); check("ed_idle", cBusy, 0);
        compareEvents("ed");

        $display("[TB] lower case with leading whitespace");
        autoTx = 1'b1;
        pushText("\r\n f4\n");
        drain("f4", 200);
        compareEvents("f4");

        $display("[TB] malformed tokens");
        pushText("A ");
        drain("mal_a", 100);
        pushText("123 ");
        drain("mal_123", 100);
        pushText("G");
        drain("mal_g", 100);
        check("mal_g_code", err_code, 2'd1);
        compareEvents("mal");

        $display("[TB] backpressure");
        autoTx = 1'b0; tbIdle = 1'b0; tbDone = 1'b0;
        pushText("FF ");
        pushText("12 ");
        cycle(); cycle(); cycle();
        anyWr = 1'b0; anyRd = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            anyWr |= cWr;
            anyRd |= cRd;
        end
        check("bp_no_wr", anyWr, 0);
        check("bp_no_rd", anyRd, 0);
        check("bp_fifo_kept", fifoQ.size(), 3);
        tbIdle = 1'b1;
        cycle(); check("bp_wr", cWr, 1); check("bp_din", cDin, 8'hFF);
        tbIdle = 1'b0;
        cycle();
        tbDone = 1'b1;
        cycle();
        tbDone = 1'b0; tbIdle = 1'b1; autoTx = 1'b1;
        drain("bp", 200);
        compareEvents("bp");

        $display("[TB] transmit timeout");
        autoTx = 1'b0; tbIdle = 1'b1; tbDone = 1'b0;
        pushText("5A ");
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (cWr) break;
        end
        check("to_wr", cWr, 1);
        errAt = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (cErr) begin
                errAt = i;
                break;
            end
        end
        check("to_cycle", errAt, TIMEOUT_CYC);
        cycle();
        check("to_code", err_code, 2'd3);
        check("to_idle", cBusy, 0);
        expQ.push_back(ev_t'{1'b1, 8'd3});
        compareEvents("to");

        $display("[TB] done on terminal count");
        pushText("5B ");
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (cWr) break;
        end
        check("tc_wr", cWr, 1);
        errSeen = 1'b0;
        for (int i = 1; i < TIMEOUT_CYC; i++) begin
            cycle();
            errSeen |= cErr;
        end
        tbDone = 1'b1;
        cycle(); errSeen |= cErr;
        tbDone = 1'b0;
        cycle();
        check("tc_no_err", errSeen, 0);
        check("tc_idle", cBusy, 0);
        compareEvents("tc");

        $display("[TB] reset mid-token");
        autoTx = 1'b1;
        pushText("E");
        drain("rst_e", 50);
        doReset(1);
        pushText("D0 ");
        drain("rst_d0", 200);
        compareEvents("rst");

        $display("[TB] random text");
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                ch = hexChars[$urandom_range(0, 21)];
            end else if (r < 9) begin
                ch = wsChars[$urandom_range(0, 2)];
            end else begin
                do ch = 8'($urandom_range(0, 255));
                while (hexVal(ch) >= 0 || isWs(ch));
            end
            fifoQ.push_back(ch);
            modelChar(ch);
        end
        pushText("\r");
        drain("rnd", 8000);
        compareEvents("rnd");

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
